// File: rtl/wl_axi_lite_mem_bridge_pkg.sv
// Shared types for the AXI-Lite to single-port SRAM bridge.
// Provides the AXI-Lite request/response structs used as the bridge's
// default port types, the response codes, and the bridge FSM encodings.
package wl_axi_lite_mem_bridge_pkg;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid;
    logic        r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
  } axi_lite_resp_t;

  localparam logic [1:0] AxilRespOkay   = 2'b00;
  localparam logic [1:0] AxilRespSlverr = 2'b10;

  localparam logic [31:0] InstrMemBaseAddr = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_RESP
  } bridge_state_e;

  typedef enum logic {
    PRIO_READ,
    PRIO_WRITE
  } bridge_prio_e;

endpackage

// File: rtl/wl_axi_lite_mem_bridge.sv
// AXI-Lite slave bridging single-beat transactions onto a single-port SRAM
// with 1-cycle read latency. One transaction in flight; reads and writes
// arbitrated round-robin when both are pending; out-of-window -> SLVERR.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   axi_lite_req_i      AW/W/B-ready/AR/R-ready from the demux
//   axi_lite_rsp_o      AW/W/AR-ready, B and R channels
//   mem_req_o/we_o      SRAM strobe and write enable
//   mem_addr_o          SRAM word index
//   mem_wdata_o/be_o    write data and byte enables (from wstrb)
//   mem_rdata_i         read data, valid the cycle after a read strobe
module wl_axi_lite_mem_bridge #(
  parameter int unsigned  MemNumWords = 1024,
  parameter logic [31:0]  BaseAddr    = 32'h0001_0000,
  parameter type axi_lite_req_t  = wl_axi_lite_mem_bridge_pkg::axi_lite_req_t,
  parameter type axi_lite_resp_t = wl_axi_lite_mem_bridge_pkg::axi_lite_resp_t,
  localparam int unsigned MemAddrWidth = $clog2(MemNumWords)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  axi_lite_req_t           axi_lite_req_i,
  output axi_lite_resp_t          axi_lite_rsp_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  output logic [3:0]              mem_be_o,
  input  logic [31:0]             mem_rdata_i
);
  import wl_axi_lite_mem_bridge_pkg::*;

  localparam logic [31:0] MemNumBytes = 32'(MemNumWords * 4);

  bridge_state_e state_q, state_d;
  bridge_prio_e  prio_q, prio_d;
  logic          rd_ok_q, rd_ok_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [1:0]    bresp_q, bresp_d;

  logic [31:0]             wr_off, rd_off;
  logic                    wr_in, rd_in;
  logic [MemAddrWidth-1:0] wr_idx, rd_idx;
  logic                    wr_pend, rd_pend, serve_rd, serve_wr;
  axi_lite_resp_t          rsp;

  logic unused_prot;
  assign unused_prot = ^{axi_lite_req_i.aw_prot, axi_lite_req_i.ar_prot};

  // Modular subtraction: addresses below the window wrap to huge offsets
  // and fail the single unsigned compare.
  always_comb begin
    wr_off = axi_lite_req_i.aw_addr - BaseAddr;
    rd_off = axi_lite_req_i.ar_addr - BaseAddr;
    wr_in  = wr_off < MemNumBytes;
    rd_in  = rd_off < MemNumBytes;
    wr_idx = wr_off[MemAddrWidth+1:2];
    rd_idx = rd_off[MemAddrWidth+1:2];
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    rd_ok_d     = rd_ok_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    bresp_d     = bresp_q;
    rsp         = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    // AW alone or W alone never counts as a pending write.
    wr_pend  = axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid;
    rd_pend  = axi_lite_req_i.ar_valid;
    serve_rd = rd_pend && (!wr_pend || (prio_q == PRIO_READ));
    serve_wr = wr_pend && !serve_rd;

    unique case (state_q)
      IDLE: begin
        if (serve_rd) begin
          rsp.ar_ready = 1'b1;
          if (wr_pend) prio_d = PRIO_WRITE;
          if (rd_in) begin
            mem_req_o  = 1'b1;
            mem_addr_o = rd_idx;
          end
          rd_ok_d = rd_in;
          state_d = RD_WAIT;
        end else if (serve_wr) begin
          rsp.aw_ready = 1'b1;
          rsp.w_ready  = 1'b1;
          if (rd_pend) prio_d = PRIO_READ;
          if (wr_in) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wr_idx;
            mem_wdata_o = axi_lite_req_i.w_data;
            mem_be_o    = axi_lite_req_i.w_strb;
          end
          bresp_d = wr_in ? AxilRespOkay : AxilRespSlverr;
          state_d = WR_RESP;
        end
      end
      RD_WAIT: begin
        rdata_d = rd_ok_q ? mem_rdata_i : '0;
        rresp_d = rd_ok_q ? AxilRespOkay : AxilRespSlverr;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        rsp.r_valid = 1'b1;
        if (axi_lite_req_i.r_ready) state_d = IDLE;
      end
      WR_RESP: begin
        rsp.b_valid = 1'b1;
        if (axi_lite_req_i.b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rsp.r_data = rdata_q;
    rsp.r_resp = rresp_q;
    rsp.b_resp = bresp_q;
  end

  assign axi_lite_rsp_o = rsp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= PRIO_READ;
      rd_ok_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= AxilRespOkay;
      bresp_q <= AxilRespOkay;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      rd_ok_q <= rd_ok_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
    end
  end

endmodule

// File: tb/tb_wl_axi_lite_mem_bridge.sv
// Self-checking bench for wl_axi_lite_mem_bridge: directed cases plus
// randomized single transactions against a word-array reference memory.
module tb_wl_axi_lite_mem_bridge;
  import wl_axi_lite_mem_bridge_pkg::*;

  localparam int unsigned WORDS  = 1024;
  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam logic [31:0] NBYTES = 32'(WORDS * 4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_req_t  req;
  axi_lite_resp_t rsp;
  logic           mem_req, mem_we;
  logic [9:0]     mem_addr;
  logic [31:0]    mem_wdata, mem_rdata, sram_q, junk;
  logic [3:0]     mem_be;
  logic           scramble;

  logic [31:0] sram [WORDS];
  logic [31:0] ref_mem [WORDS];
  bit          seeded = 1'b0;
  int unsigned req_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  wl_axi_lite_mem_bridge #(.MemNumWords(WORDS), .BaseAddr(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_lite_req_i(req), .axi_lite_rsp_o(rsp),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] pattern(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // SRAM environment: registered read port, byte-enabled write port.
  assign mem_rdata = scramble ? junk : sram_q;
  always @(posedge clk) begin
    junk <= $urandom;
    if (!seeded) begin
      for (int i = 0; i < WORDS; i++) sram[i] = pattern(i);
      seeded = 1'b1;
    end else if (mem_req) begin
      req_cnt++;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        sram_q <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return off < NBYTES;
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - BASE) >> 2);
  endfunction

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdly);
    bit inr, got;
    int unsigned c0;
    inr = in_win(addr);
    c0  = req_cnt;
    got = 1'b0;
    req.aw_addr = addr; req.aw_prot = 3'($urandom); req.aw_valid = 1'b1;
    req.w_data = data; req.w_strb = strb; req.w_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (rsp.aw_ready) begin
        got = 1'b1;
        check("wr_wready", rsp.w_ready, 1);
        check("wr_req", mem_req, inr);
        if (inr) begin
          check("wr_addr", mem_addr, word_of(addr));
          check("wr_be", mem_be, strb);
          check("wr_data", mem_wdata, data);
        end
      end
      step();
    end
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    if (!got) begin
      check("wr_timeout", 0, 1);
      return;
    end
    if (inr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[word_of(addr)][8*b +: 8] = data[8*b +: 8];
    req.b_ready = (bdly == 0);
    #1;
    check("wr_bvalid", rsp.b_valid, 1);
    check("wr_bresp", rsp.b_resp, inr ? 2'b00 : 2'b10);
    for (int d = 0; d < bdly; d++) begin
      step();
      if (d == bdly - 1) req.b_ready = 1'b1;
      #1;
      check("wr_bhold", {rsp.b_valid, rsp.b_resp, rsp.aw_ready}, {1'b1, inr ? 2'b00 : 2'b10, 1'b0});
    end
    step();
    req.b_ready = 1'b0;
    #1;
    check("wr_bdone", rsp.b_valid, 0);
    check("wr_reqcnt", req_cnt - c0, inr);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int rdly, output logic [31:0] data);
    bit inr, got;
    int unsigned c0;
    logic [31:0] exp;
    inr  = in_win(addr);
    exp  = inr ? ref_mem[word_of(addr)] : 32'h0;
    c0   = req_cnt;
    got  = 1'b0;
    data = 32'h0;
    req.ar_addr = addr; req.ar_prot = 3'($urandom); req.ar_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (rsp.ar_ready) begin
        got = 1'b1;
        check("rd_req", mem_req, inr);
        if (inr) begin
          check("rd_addr", mem_addr, word_of(addr));
          check("rd_we", mem_we, 0);
        end
      end
      step();
    end
    req.ar_valid = 1'b0;
    if (!got) begin
      check("rd_timeout", 0, 1);
      return;
    end
    req.r_ready = 1'b0;
    #1;
    check("rd_early", rsp.r_valid, 0);
    step();
    req.r_ready = (rdly == 0);
    #1;
    check("rd_rvalid", rsp.r_valid, 1);
    check("rd_rdata", rsp.r_data, exp);
    check("rd_rresp", rsp.r_resp, inr ? 2'b00 : 2'b10);
    data = rsp.r_data;
    for (int d = 0; d < rdly; d++) begin
      step();
      if (d == rdly - 1) req.r_ready = 1'b1;
      #1;
      check("rd_rhold", {rsp.r_valid, rsp.r_data}, {1'b1, exp});
    end
    step();
    req.r_ready = 1'b0;
    #1;
    check("rd_rdone", rsp.r_valid, 0);
    check("rd_reqcnt", req_cnt - c0, inr);
  endtask

  initial begin
    logic [31:0] d, a, wd;
    logic [31:0] ra [2];
    logic [31:0] wa [2];
    logic [31:0] wdat [2];
    logic [31:0] rexp [$];
    bit ord [4];
    int ri, wi, n, nb, mism;
    int unsigned c0;
    bit fr, fw;

    req = '0;
    scramble = 1'b0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = pattern(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp", rsp, '0);
    check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, '0);

    // Read and write both pending straight out of reset: R, W, R, W.
    ra[0] = BASE + 32'h100; ra[1] = BASE + 32'h104;
    wa[0] = BASE + 32'h200; wa[1] = BASE + 32'h204;
    wdat[0] = $urandom; wdat[1] = $urandom;
    ri = 0; wi = 0; n = 0; nb = 0; c0 = req_cnt;
    rst_n = 1'b1;
    req.ar_addr = ra[0]; req.ar_valid = 1'b1;
    req.aw_addr = wa[0]; req.w_data = wdat[0]; req.w_strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    req.r_ready = 1'b1; req.b_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      fr = rsp.ar_ready;
      fw = rsp.aw_ready && rsp.w_ready;
      if (fr && fw) check("arb_excl", 1, 0);
      if (fr && n < 4) begin
        ord[n] = 1'b0; n++;
        rexp.push_back(ref_mem[word_of(ra[ri])]);
      end
      if (fw && n < 4) begin
        ord[n] = 1'b1; n++;
        ref_mem[word_of(wa[wi])] = wdat[wi];
      end
      if (rsp.r_valid) begin
        if (rexp.size() > 0) check("arb_rdata", rsp.r_data, rexp.pop_front());
        else check("arb_spurious_r", 1, 0);
      end
      if (rsp.b_valid) begin
        nb++;
        check("arb_bresp", rsp.b_resp, 0);
      end
      step();
      if (fr) begin
        ri++;
        if (ri < 2) req.ar_addr = ra[ri]; else req.ar_valid = 1'b0;
      end
      if (fw) begin
        wi++;
        if (wi < 2) begin
          req.aw_addr = wa[wi]; req.w_data = wdat[wi];
        end else begin
          req.aw_valid = 1'b0; req.w_valid = 1'b0;
        end
      end
    end
    req.r_ready = 1'b0; req.b_ready = 1'b0;
    check("arb_count", {8'(ri), 8'(wi), 8'(nb), 8'(rexp.size())}, {8'd2, 8'd2, 8'd2, 8'd0});
    check("arb_order", {ord[0], ord[1], ord[2], ord[3]}, 4'b0101);
    check("arb_reqcnt", req_cnt - c0, 4);

    // Directed accesses.
    write_txn(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    read_txn(BASE + 32'h10, 0, d);
    check("deadbeef", d, 32'hDEAD_BEEF);
    write_txn(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 1);
    write_txn(BASE + 32'h10, 32'h0000_00AA, 4'h1, 0);
    read_txn(BASE + 32'h10, 2, d);
    check("byte_merge", d, 32'hFFFF_FFAA);
    write_txn(BASE + 32'h14, 32'h1234_5678, 4'h0, 0);
    read_txn(BASE + 32'h16, 0, d);
    check("be_zero", d, pattern(5));
    read_txn(BASE + NBYTES, 0, d);
    check("oor_high", d, 0);
    read_txn(BASE - 32'h4, 1, d);
    check("oor_low", d, 0);
    write_txn(BASE + NBYTES, 32'hCAFE_F00D, 4'hF, 0);
    write_txn(BASE - 32'h4, 32'hCAFE_F00D, 4'hF, 2);
    read_txn(BASE + NBYTES - 32'h4, 0, d);

    // AW waits for W: no ready and no access until both are valid.
    wd = $urandom; c0 = req_cnt;
    req.aw_addr = BASE + 32'h80; req.aw_valid = 1'b1;
    req.w_data = wd; req.w_strb = 4'hF; req.w_valid = 1'b0;
    repeat (5) begin
      #1;
      check("stall_rdy", {rsp.aw_ready, rsp.w_ready, mem_req}, 0);
      step();
    end
    req.w_valid = 1'b1;
    #1;
    check("stall_go", {rsp.aw_ready, rsp.w_ready, mem_req, mem_we}, 4'hF);
    check("stall_addr", mem_addr, 32);
    step();
    ref_mem[32] = wd;
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.b_ready = 1'b1;
    #1;
    check("stall_b", {rsp.b_valid, rsp.b_resp}, 3'b100);
    step();
    req.b_ready = 1'b0;
    check("stall_reqcnt", req_cnt - c0, 1);

    // Response held under r_ready low while SRAM output churns; then reset.
    req.ar_addr = BASE + 32'h80; req.ar_valid = 1'b1;
    #1;
    check("hold_ar", rsp.ar_ready, 1);
    step();
    req.ar_valid = 1'b0;
    step();
    scramble = 1'b1;
    req.ar_valid = 1'b1; req.aw_addr = BASE; req.aw_valid = 1'b1; req.w_valid = 1'b1;
    req.r_ready = 1'b0;
    repeat (3) begin
      #1;
      check("hold_r", {rsp.r_valid, rsp.r_data, rsp.r_resp}, {1'b1, wd, 2'b00});
      check("hold_nordy", {rsp.ar_ready, rsp.aw_ready, rsp.w_ready, mem_req}, 0);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {rsp.r_valid, rsp.b_valid}, 0);
    req = '0;
    scramble = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    #1;
    check("rst_idle", rsp, '0);

    // Randomized single transactions.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + NBYTES + $urandom_range(0, 64);
        1:       a = BASE - 32'd1 - $urandom_range(0, 64);
        2:       a = $urandom;
        3, 4, 5: a = BASE + $urandom_range(0, NBYTES - 1);
        default: a = BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 1) == 1)
        write_txn(a, $urandom, 4'($urandom), $urandom_range(0, 3));
      else
        read_txn(a, $urandom_range(0, 3), d);
    end

    mism = 0;
    for (int i = 0; i < WORDS; i++) if (sram[i] !== ref_mem[i]) mism++;
    check("sram_vs_ref", mism, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wl_axi_lite_mem_bridge.md
Name: wl_axi_lite_mem_bridge

Overview:
- AXI-Lite slave that converts single-beat AXI-Lite transactions into accesses on a single-port SRAM with fixed 1-cycle read latency.
- Instantiated once for the core instruction memory and once for the core data memory. Each instance sits directly downstream of the wakelet AXI-Lite address demux, on the cluster-bus (rw) path.
- Handles one transaction at a time.
- Arbitrates reads against writes round-robin.
- Rejects out-of-window addresses with SLVERR.

Parameters:
- MemNumWords, 1024, SRAM depth in DataWidth words; must be a power of two, ≥2.
- BaseAddr, 32'h0001_0000, byte base address of the memory window (wl_pkg::InstrMemBaseAddr or DataMemBaseAddr).
- axi_lite_req_t, wl_pkg::axi_lite_req_t, AXI-Lite request struct.
- axi_lite_resp_t, wl_pkg::axi_lite_resp_t, AXI-Lite response struct.
- Derived localparam MemAddrWidth = $clog2(MemNumWords).
- Derived localparam MemNumBytes = MemNumWords*4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- axi_lite_req_i  in  axi_lite_req_t  AW/W/B-ready/AR/R-ready from the demux.
- axi_lite_rsp_o  out  axi_lite_resp_t  AW/W/AR-ready, B and R channels.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  MemAddrWidth  SRAM word index.
- mem_wdata_o  out  32  write data.
- mem_be_o  out  4  byte enables, taken from wstrb.
- mem_rdata_i  in  32  read data, valid the cycle after a read strobe.

Behaviour:
- Reset values:
  - All ready, bvalid, rvalid and mem_req_o are 0.
  - bresp, rresp, rdata, mem_addr_o, mem_wdata_o and mem_be_o are 0.
  - FSM is in IDLE; priority register prio_q = READ.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_RESP.
- IDLE:
  - A write is pending when aw_valid && w_valid. AW without W, or W without AW, is never accepted; it stalls with no ready asserted.
  - A read is pending when ar_valid.
  - If both are pending, serve the kind indicated by prio_q, then set prio_q to the other kind. If only one is pending, serve it and leave prio_q unchanged.
- IDLE, write served:
  - aw_ready and w_ready are asserted combinationally in the same cycle.
  - In-range: mem_req_o=1, mem_we_o=1, mem_be_o=wstrb.
  - Latch bresp (in-range OKAY 2'b00, else SLVERR 2'b10).
  - Next state WR_RESP.
- IDLE, read served:
  - ar_ready is asserted.
  - In-range: mem_req_o=1, mem_we_o=0.
  - Latch the range flag.
  - Next state RD_WAIT.
- RD_WAIT (exactly 1 cycle):
  - Capture mem_rdata_i into the rdata register; capture 0 if out of range.
  - Set rresp to OKAY, or SLVERR if out of range.
  - Next state RD_RESP.
- RD_RESP:
  - r_valid=1; rdata and rresp are held stable.
  - Leave for IDLE on r_ready.
- WR_RESP:
  - b_valid=1; bresp is held.
  - Leave for IDLE on b_ready.
- Ready outputs are never asserted outside IDLE. No new request is accepted in the cycle a response handshake completes.
- Address decoding:
  - offset = addr − BaseAddr, computed in 32-bit modular arithmetic.
  - In-range iff offset < MemNumBytes (unsigned). Addresses below BaseAddr wrap to large offsets and are therefore out of range.
  - mem_addr_o = offset[MemAddrWidth+1:2]. Byte-offset bits [1:0] are ignored, so unaligned accesses act on the containing word.
- Out-of-range accesses never assert mem_req_o.
- wstrb=4'b0000 in range: mem_req_o still asserts with be=0; response OKAY.
- Latency, no backpressure:
  - Write: B valid 1 cycle after AW/W handshake.
  - Read: R valid 2 cycles after AR handshake.
- Reset asserted mid-transaction returns to IDLE immediately and drops any pending response; the transaction is not replayed.
- aw_prot and ar_prot are ignored.

Decomposition:
- No additions to wl_pkg. The bridge uses the existing axi_lite_* types and the memory-map constants as instantiation parameters.
- Add to wl_pkg only an enum wl_axil_resp_e {OKAY=2'b00, SLVERR=2'b10} if a second user appears; until then keep it as a localparam.
- No sub-module. The range-check plus index extraction is a single always_comb; the FSM and response registers form one always_ff.

Test Plan:
- Write 0xDEADBEEF with wstrb 4'hF to BaseAddr+0x10, then read BaseAddr+0x10 → mem_addr_o=4, mem_be_o=F; bresp OKAY 1 cycle after handshake; rdata=0xDEADBEEF with rresp OKAY 2 cycles after AR.
- Write 0x000000AA with wstrb 4'h1 over 0xFFFFFFFF at word 4, then read → 0xFFFFFFAA.
- Read BaseAddr+MemNumBytes, and separately BaseAddr−4 → mem_req_o never asserts; rresp SLVERR, rdata 0. Same for a write → bresp SLVERR, SRAM unchanged.
- AR and AW+W all valid from reset for 4 transactions → service order read, write, read, write; at most one mem_req_o per transaction.
- aw_valid held for 5 cycles with w_valid low, then w_valid raised → no aw_ready until w_valid; access occurs in the cycle both are valid.
- r_ready held low for 3 cycles in RD_RESP while mem_rdata_i changes → rdata stable, no ready asserted. Then rst_ni pulsed low during RD_RESP → r_valid drops asynchronously, FSM returns to IDLE.
